// File: rtl/mac_pkg.sv
// Shared width defaults and accumulate arithmetic for the mac_vec_pipe slice.
package mac_pkg;

   localparam int DEF_WIDTH       = 14;
   localparam int DEF_ACC_WIDTH   = 28;
   localparam int DEF_PIPE_STAGES = 1;
   localparam int DEF_VEC_LEN     = 8;

   // Working width of the generic adder; accumulator widths must stay below it.
   localparam int MAX_W = 128;

   typedef struct packed {
      logic signed [MAX_W-1:0] sum;
      logic                    ovf;
   } add_res_t;

   function automatic int count_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // x and y arrive sign-extended from w bits; the sum is returned sign-extended from w bits.
   function automatic add_res_t sat_add(input logic signed [MAX_W-1:0] x,
                                        input logic signed [MAX_W-1:0] y,
                                        input int                      w,
                                        input logic                    saturate);
      add_res_t                r;
      logic signed [MAX_W-1:0] s;
      logic signed [MAX_W-1:0] lim;
      s     = x + y;
      r.ovf = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
      lim   = (MAX_W'(1) <<< (w - 1)) - MAX_W'(1);
      if (saturate && r.ovf)
         r.sum = x[w-1] ? ~lim : lim;
      else
         r.sum = (s <<< (MAX_W - w)) >>> (MAX_W - w);
      return r;
   endfunction

endpackage

// File: rtl/mac_mult_pipe.sv
// Signed multiplier followed by a PIPE_STAGES-deep product/valid delay line with flush.
module mac_mult_pipe
   import mac_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int PIPE_STAGES = DEF_PIPE_STAGES
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear,
   input  logic signed [WIDTH-1:0]   a,
   input  logic signed [WIDTH-1:0]   b,
   input  logic                      vld,
   output logic signed [2*WIDTH-1:0] prod,
   output logic                      prod_vld
);

   logic signed [2*WIDTH-1:0] prod_p0;

   assign prod_p0 = (2*WIDTH)'(a) * (2*WIDTH)'(b);

   if (PIPE_STAGES == 0) begin : g_comb
      assign prod     = prod_p0;
      assign prod_vld = vld;
   end else begin : g_reg
      logic signed [2*WIDTH-1:0] prod_q [PIPE_STAGES];
      logic [PIPE_STAGES-1:0]    vld_q;

      // ---- multiplier register stages ----
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            vld_q <= '0;
         end else if (clear) begin
            vld_q <= '0;
         end else begin
            vld_q[0] <= vld;
            for (int i = 1; i < PIPE_STAGES; i++)
               vld_q[i] <= vld_q[i-1];
         end
      end

      always_ff @(posedge clk) begin
         prod_q[0] <= prod_p0;
         for (int i = 1; i < PIPE_STAGES; i++)
            prod_q[i] <= prod_q[i-1];
      end

      assign prod     = prod_q[PIPE_STAGES-1];
      assign prod_vld = vld_q[PIPE_STAGES-1];
   end

endmodule

// File: rtl/mac_vec_pipe.sv
// Pipelined signed dot-product MAC emitting one result per VEC_LEN valid products.
// Define MAC_SAT_EN to make every accumulate add saturate instead of wrap.
module mac_vec_pipe
   import mac_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
   parameter int PIPE_STAGES = DEF_PIPE_STAGES,
   parameter int VEC_LEN     = DEF_VEC_LEN
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic signed [WIDTH-1:0]     a,
   input  logic signed [WIDTH-1:0]     b,
   input  logic                        valid_in,
   input  logic                        clear,
   output logic signed [ACC_WIDTH-1:0] f,
   output logic                        valid_out,
   output logic                        overflow
);

   localparam int                 COUNT_W = count_w(VEC_LEN);
   localparam logic [COUNT_W-1:0] LAST    = COUNT_W'(VEC_LEN - 1);
`ifdef MAC_SAT_EN
   localparam logic SAT = 1'b1;
`else
   localparam logic SAT = 1'b0;
`endif

   function automatic logic [ACC_WIDTH:0] acc_add(input logic signed [ACC_WIDTH-1:0] x,
                                                  input logic signed [2*WIDTH-1:0]   p);
      add_res_t r;
      r = sat_add(MAX_W'(x), MAX_W'(p), ACC_WIDTH, SAT);
      return {r.ovf, r.sum[ACC_WIDTH-1:0]};
   endfunction

   logic signed [WIDTH-1:0]     a_p0;
   logic signed [WIDTH-1:0]     b_p0;
   logic                        vld_p0;
   logic signed [2*WIDTH-1:0]   prod_p1;
   logic                        vld_p1;
   logic [COUNT_W-1:0]          count;
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] acc_base;
   logic signed [ACC_WIDTH-1:0] sum;
   logic                        ovf_add;
   logic                        ovf_sticky;

   // ---- stage 0: operand capture ----
   always_ff @(posedge clk) begin
      a_p0 <= a;
      b_p0 <= b;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         vld_p0 <= 1'b0;
      else
         vld_p0 <= valid_in & ~clear;
   end

   // ---- multiply and delay line ----
   mac_mult_pipe #(
      .WIDTH       (WIDTH),
      .PIPE_STAGES (PIPE_STAGES)
   ) u_mult (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .a        (a_p0),
      .b        (b_p0),
      .vld      (vld_p0),
      .prod     (prod_p1),
      .prod_vld (vld_p1)
   );

   // ---- accumulate and output ----
   always_comb begin
      acc_base       = (count == '0) ? '0 : acc;
      {ovf_add, sum} = acc_add(acc_base, prod_p1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count      <= '0;
         acc        <= '0;
         ovf_sticky <= 1'b0;
         f          <= '0;
         valid_out  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         if (clear) begin
            count      <= '0;
            acc        <= '0;
            ovf_sticky <= 1'b0;
         end else if (vld_p1) begin
            acc <= sum;
            if (count == LAST) begin
               count      <= '0;
               ovf_sticky <= 1'b0;
               f          <= sum;
               valid_out  <= 1'b1;
               overflow   <= ovf_sticky | ovf_add;
            end else begin
               count      <= count + COUNT_W'(1);
               ovf_sticky <= ovf_sticky | ovf_add;
            end
         end
      end
   end

endmodule

// File: tb/tb_mac_vec_pipe.sv
// Directed bench for mac_vec_pipe: main config (VEC_LEN=4, PIPE_STAGES=1) plus a VEC_LEN=1, PIPE_STAGES=0 instance.
module tb_mac_vec_pipe;

   logic               clk;
   logic               reset;
   logic signed [13:0] a, b, a2, b2;
   logic               valid_in, clear, valid2, clear2;
   logic signed [27:0] f, f2;
   logic               valid_out, overflow, valid_out2, overflow2;

   int                 checks = 0;
   int                 errors = 0;
   int                 cyc = 0;
   int                 pulses = 0;
   int                 last_in = 0;
   int                 pulse_step [4];
   logic signed [27:0] pulse_f [4];
   logic               last_ovf;

   mac_vec_pipe #(.WIDTH(14), .ACC_WIDTH(28), .PIPE_STAGES(1), .VEC_LEN(4)) dut (
      .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear(clear),
      .f(f), .valid_out(valid_out), .overflow(overflow)
   );

   mac_vec_pipe #(.WIDTH(14), .ACC_WIDTH(28), .PIPE_STAGES(0), .VEC_LEN(1)) dut1 (
      .clk(clk), .reset(reset), .a(a2), .b(b2), .valid_in(valid2), .clear(clear2),
      .f(f2), .valid_out(valid_out2), .overflow(overflow2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int sa, input int sb, input logic v, input logic c);
      a = 14'(sa);
      b = 14'(sb);
      valid_in = v;
      clear = c;
      @(posedge clk);
      #1;
      cyc++;
      if (valid_out) begin
         if (pulses < 4) begin
            pulse_step[pulses] = cyc;
            pulse_f[pulses]    = f;
         end
         pulses++;
         last_ovf = overflow;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_reset;
      a = '0; b = '0; valid_in = 1'b0; clear = 1'b0;
      a2 = '0; b2 = '0; valid2 = 1'b0; clear2 = 1'b0;
      reset = 1'b0;
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (f !== 28'sd0) begin errors++; $display("FAIL reset_f: got %0d expected 0", f); end
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %b expected 0", valid_out); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      checks++; if (f2 !== 28'sd0) begin errors++; $display("FAIL reset_f2: got %0d expected 0", f2); end
      checks++; if (valid_out2 !== 1'b0) begin errors++; $display("FAIL reset_valid_out2: got %b expected 0", valid_out2); end
      reset = 1'b0;
      idle(2);
   endtask

   task automatic test_basic;
      pulses = 0;
      for (int i = 0; i < 4; i++) step(3, 5, 1'b1, 1'b0);
      last_in = cyc;
      idle(5);
      checks++; if (pulses !== 1) begin errors++; $display("FAIL basic_pulses: got %0d expected 1", pulses); end
      checks++; if (pulse_step[0] !== last_in + 2) begin errors++; $display("FAIL basic_latency: got step %0d expected %0d", pulse_step[0], last_in + 2); end
      checks++; if (pulse_f[0] !== 28'sd60) begin errors++; $display("FAIL basic_f: got %0d expected 60", pulse_f[0]); end
      checks++; if (last_ovf !== 1'b0) begin errors++; $display("FAIL basic_overflow: got %b expected 0", last_ovf); end
      checks++; if (f !== 28'sd60) begin errors++; $display("FAIL basic_f_held: got %0d expected 60", f); end
   endtask

   task automatic test_bubbles;
      pulses = 0;
      step(-8192, 8191, 1'b1, 1'b0);
      idle(2);
      step(100, -2, 1'b1, 1'b0);
      idle(1);
      step(0, 7, 1'b1, 1'b0);
      step(1, 1, 1'b1, 1'b0);
      last_in = cyc;
      idle(5);
      checks++; if (pulses !== 1) begin errors++; $display("FAIL bubble_pulses: got %0d expected 1", pulses); end
      checks++; if (pulse_step[0] !== last_in + 2) begin errors++; $display("FAIL bubble_latency: got step %0d expected %0d", pulse_step[0], last_in + 2); end
      checks++; if (pulse_f[0] !== -28'sd67100871) begin errors++; $display("FAIL bubble_f: got %0d expected -67100871", pulse_f[0]); end
   endtask

   task automatic test_overflow;
      logic signed [27:0] exp_f;
`ifdef MAC_SAT_EN
      exp_f = 28'sd134217727;
`else
      exp_f = 28'sd0;
`endif
      pulses = 0;
      for (int i = 0; i < 4; i++) step(-8192, -8192, 1'b1, 1'b0);
      idle(5);
      checks++; if (pulses !== 1) begin errors++; $display("FAIL ovf_pulses: got %0d expected 1", pulses); end
      checks++; if (pulse_f[0] !== exp_f) begin errors++; $display("FAIL ovf_f: got %0d expected %0d", pulse_f[0], exp_f); end
      checks++; if (last_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", last_ovf); end
   endtask

   task automatic test_clear;
      pulses = 0;
      step(7, 7, 1'b1, 1'b0);
      step(7, 7, 1'b1, 1'b0);
      step(7, 7, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) step(1, 1, 1'b1, 1'b0);
      last_in = cyc;
      idle(5);
      checks++; if (pulses !== 1) begin errors++; $display("FAIL clear_pulses: got %0d expected 1", pulses); end
      checks++; if (pulse_step[0] !== last_in + 2) begin errors++; $display("FAIL clear_latency: got step %0d expected %0d", pulse_step[0], last_in + 2); end
      checks++; if (pulse_f[0] !== 28'sd4) begin errors++; $display("FAIL clear_f: got %0d expected 4", pulse_f[0]); end
      checks++; if (last_ovf !== 1'b0) begin errors++; $display("FAIL clear_overflow: got %b expected 0", last_ovf); end
   endtask

   task automatic test_back_to_back;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         step(2, 2, 1'b1, 1'b0);
         if (i == 3) last_in = cyc;
      end
      idle(5);
      checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
      checks++; if (pulse_step[0] !== last_in + 2) begin errors++; $display("FAIL b2b_latency: got step %0d expected %0d", pulse_step[0], last_in + 2); end
      checks++; if (pulse_step[1] - pulse_step[0] !== 4) begin errors++; $display("FAIL b2b_spacing: got %0d expected 4", pulse_step[1] - pulse_step[0]); end
      checks++; if (pulse_f[0] !== 28'sd16) begin errors++; $display("FAIL b2b_f0: got %0d expected 16", pulse_f[0]); end
      checks++; if (pulse_f[1] !== 28'sd16) begin errors++; $display("FAIL b2b_f1: got %0d expected 16", pulse_f[1]); end
   endtask

   task automatic test_reset_mid_vector;
      pulses = 0;
      step(2, 2, 1'b1, 1'b0);
      step(2, 2, 1'b1, 1'b0);
      valid_in = 1'b0;
      #2 reset = 1'b1;
      #1;
      checks++; if (f !== 28'sd0) begin errors++; $display("FAIL async_reset_f: got %0d expected 0", f); end
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL async_reset_valid_out: got %b expected 0", valid_out); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL async_reset_overflow: got %b expected 0", overflow); end
      @(posedge clk);
      #1 reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 4; i++) step(1, 1, 1'b1, 1'b0);
      last_in = cyc;
      idle(5);
      checks++; if (pulses !== 1) begin errors++; $display("FAIL post_reset_pulses: got %0d expected 1", pulses); end
      checks++; if (pulse_step[0] !== last_in + 2) begin errors++; $display("FAIL post_reset_latency: got step %0d expected %0d", pulse_step[0], last_in + 2); end
      checks++; if (pulse_f[0] !== 28'sd4) begin errors++; $display("FAIL post_reset_f: got %0d expected 4", pulse_f[0]); end
   endtask

   task automatic test_sweep_vec1;
      int                 da [5] = '{-8192, 8191, 8191, -1, 0};
      int                 db [5] = '{-8192, -8192, 8191, 1, -5};
      int                 sa, sb;
      logic signed [27:0] exp_prev;
      logic               ovf_seen;
      exp_prev = '0;
      ovf_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i < 5) begin
            sa = da[i];
            sb = db[i];
         end else begin
            sa = int'($urandom_range(0, 16383)) - 8192;
            sb = int'($urandom_range(0, 16383)) - 8192;
         end
         a2 = 14'(sa);
         b2 = 14'(sb);
         valid2 = 1'b1;
         idle(1);
         ovf_seen = ovf_seen | (valid_out2 & overflow2);
         if (i > 0) begin
            checks++; if (valid_out2 !== 1'b1) begin errors++; $display("FAIL vec1_valid[%0d]: got %b expected 1", i, valid_out2); end
            checks++; if (f2 !== exp_prev) begin errors++; $display("FAIL vec1_f[%0d]: got %0d expected %0d", i, f2, exp_prev); end
         end
         exp_prev = 28'(sa * sb);
      end
      valid2 = 1'b0;
      idle(1);
      checks++; if (f2 !== exp_prev) begin errors++; $display("FAIL vec1_f_last: got %0d expected %0d", f2, exp_prev); end
      idle(1);
      checks++; if (valid_out2 !== 1'b0) begin errors++; $display("FAIL vec1_bubble_valid: got %b expected 0", valid_out2); end
      checks++; if (f2 !== exp_prev) begin errors++; $display("FAIL vec1_f_held: got %0d expected %0d", f2, exp_prev); end
      checks++; if (ovf_seen !== 1'b0) begin errors++; $display("FAIL vec1_overflow: got %b expected 0", ovf_seen); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_bubbles;
      test_overflow;
      test_clear;
      test_back_to_back;
      test_reset_mid_vector;
      test_sweep_vec1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
